fifo8_16: RTL

- 8-entry, 16-bit first-word-fall-through FIFO with a valid/ready handshake on both sides.
- Storage is eight 16-bit registers. The write side decodes the write pointer into one-hot load enables, 8-way demux style. The read side selects the head entry with an 8-way 16-bit mux driven by the 3-bit read pointer.
- Sits upstream of any consumer of 16-bit words and decouples a producer from it. It is the first sequential buffering stage built on the mux/demux primitives.

---
 rtl/fifo8_16.sv | 73 +++++++
 1 files changed

// File: rtl/fifo8_16.sv
// fifo8_16: 8-entry x 16-bit first-word-fall-through FIFO with valid/ready on both sides.
// Ports:
//   clock, reset_n         - rising-edge clock, asynchronous active-low reset
//   in_data/in_valid/in_ready    - write side handshake (push on in_valid && in_ready)
//   out_data/out_valid/out_ready - read side handshake (pop on out_valid && out_ready)
//   full, empty            - occupancy flags (count == 8 / count == 0)
//   level, almost_full     - only with FIFO8_LEVEL_EN: count, and count >= 6
module fifo8_16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full,
`ifdef FIFO8_LEVEL_EN
    output logic             empty,
    output logic [3:0]       level,
    output logic             almost_full
`else
    output logic             empty
`endif
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [2:0]       wr_ptr, rd_ptr;
    logic [3:0]       count;
    logic             push, pop;
    logic [DEPTH-1:0] load;

    assign full      = count == 4'(DEPTH);
    assign empty     = count == 4'd0;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];
    // One-hot write demux: only the register addressed by wr_ptr loads.
    assign load      = push ? DEPTH'(1) << wr_ptr : '0;

`ifdef FIFO8_LEVEL_EN
    assign level       = count;
    assign almost_full = count >= 4'd6;
`endif

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_mem
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    mem[g] <= '0;
                else if (load[g])
                    mem[g] <= in_data;
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            wr_ptr <= push ? wr_ptr + 3'd1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 3'd1 : rd_ptr;
            count  <= count + 4'(push) - 4'(pop);
        end
    end
endmodule
